audio_stream_recorder: RTL and testbench

Multichannel record/playback engine between the audio codec sample interface and SDRAM, generalising the fixed 16-bit mono data_in/data_out path.
- On each sample strobe in RECORD mode, captures CHANNELS samples of DATA_W bits and writes them to memory over an Avalon-MM master.
- In PLAY mode, reads the samples back and presents them on a registered output bus.
- Sits between the codec serialiser and the SDRAM controller port.

---
 rtl/audio_stream_recorder.sv | 206 ++++++++++++++++++++
 tb/tb_audio_stream_recorder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_recorder.sv
// Multichannel audio record/playback engine: codec frames <-> SDRAM via Avalon-MM master.
// Optional build macro LOOP_PLAYBACK_EN: playback wraps to frame 0 instead of stopping.
module audio_stream_recorder #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 65536,
    parameter int ADDR_W   = 17
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic                         sync_in,
    input  logic                         record_btn_in,
    input  logic                         play_btn_in,
    input  logic [CHANNELS*DATA_W-1:0]   data_in,
    output logic [CHANNELS*DATA_W-1:0]   data_out,
    output logic [ADDR_W-1:0]            avm_address,
    output logic                         avm_write,
    output logic [DATA_W-1:0]            avm_writedata,
    output logic                         avm_read,
    input  logic [DATA_W-1:0]            avm_readdata,
    input  logic                         avm_readdatavalid,
    input  logic                         avm_waitrequest,
    output logic [1:0]                   mode,
    output logic [ADDR_W-1:0]            rec_len,
    output logic                         overrun
);

    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FRAME_W = CHANNELS * DATA_W;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REC_WAIT  = 3'd1;
    localparam logic [2:0] S_REC_WR    = 3'd2;
    localparam logic [2:0] S_PLAY_WAIT = 3'd3;
    localparam logic [2:0] S_PLAY_RD   = 3'd4;

    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

    logic [2:0]         state;
    logic               rec_q;
    logic               play_q;
    logic [ADDR_W-1:0]  ptr;
    logic [CH_W-1:0]    ch;
    logic [ADDR_W-1:0]  rec_len_q;
    logic               overrun_q;
    logic               stop_pending;
    logic               rd_pending;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] staging;
    logic [FRAME_W-1:0] data_out_q;

    logic               rec_edge;
    logic               play_edge;
    logic [ADDR_W-1:0]  ptr_inc;
    logic               last_ch;
    logic               rd_done;
    logic [ADDR_W-1:0]  word_addr;
    logic [FRAME_W-1:0] frame_next;

    assign rec_edge  = record_btn_in & ~rec_q;
    assign play_edge = play_btn_in & ~play_q;
    assign ptr_inc   = ptr + 1'b1;
    assign last_ch   = (ch == LAST_CH);
    assign rd_done   = (state == S_PLAY_RD) && rd_pending && avm_readdatavalid;
    assign word_addr = ADDR_W'(ptr * CHANNELS) + ADDR_W'(ch);

    // The final channel is merged straight from the bus so the whole frame lands in one edge.
    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        frame_next = staging;
        frame_next[ch*DATA_W +: DATA_W] = avm_readdata;
    end

    // Bus strobes decode from state so an asynchronous reset drops them immediately.
    assign avm_write     = (state == S_REC_WR);
    assign avm_read      = (state == S_PLAY_RD) && !rd_pending;
    assign avm_address   = (avm_write || avm_read) ? word_addr : '0;
    assign avm_writedata = avm_write ? shadow[ch*DATA_W +: DATA_W] : '0;

    always_comb begin
        mode = 2'd0;
        case (state)
            S_REC_WAIT, S_REC_WR:   mode = 2'd1;
            S_PLAY_WAIT, S_PLAY_RD: mode = 2'd2;
            default:                mode = 2'd0;
        endcase
    end

    assign data_out = data_out_q;
    assign rec_len  = rec_len_q;
    assign overrun  = overrun_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state        <= S_IDLE;
            rec_q        <= 1'b0;
            play_q       <= 1'b0;
            ptr          <= '0;
            ch           <= '0;
            rec_len_q    <= '0;
            overrun_q    <= 1'b0;
            stop_pending <= 1'b0;
            rd_pending   <= 1'b0;
            shadow       <= '0;
            staging      <= '0;
            data_out_q   <= '0;
        end else begin
            rec_q  <= record_btn_in;
            play_q <= play_btn_in;

            case (state)
                S_IDLE: begin
                    if (rec_edge) begin
                        state        <= S_REC_WAIT;
                        ptr          <= '0;
                        rec_len_q    <= '0;
                        overrun_q    <= 1'b0;
                        stop_pending <= 1'b0;
                    end else if (play_edge && (rec_len_q != '0)) begin
                        state        <= S_PLAY_WAIT;
                        ptr          <= '0;
                        stop_pending <= 1'b0;
                    end
                end

                S_REC_WAIT: begin
                    if (rec_edge) begin
                        state <= S_IDLE;
                    end else if (sync_in) begin
                        shadow <= data_in;
                        ch     <= '0;
                        state  <= S_REC_WR;
                    end
                end

                S_REC_WR: begin
                    if (sync_in)
                        overrun_q <= 1'b1;
                    if (rec_edge)
                        stop_pending <= 1'b1;
                    if (!avm_waitrequest) begin
                        if (last_ch) begin
                            ptr       <= ptr_inc;
                            rec_len_q <= ptr_inc;
                            // A stop edge in the final accept cycle must not be lost.
                            if ((ptr_inc == PTR_MAX) || stop_pending || rec_edge)
                                state <= S_IDLE;
                            else
                                state <= S_REC_WAIT;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end
                end

                S_PLAY_WAIT: begin
                    if (play_edge) begin
                        state <= S_IDLE;
                    end else if (sync_in) begin
                        ch         <= '0;
                        rd_pending <= 1'b0;
                        state      <= S_PLAY_RD;
                    end
                end

                S_PLAY_RD: begin
                    if (sync_in)
                        overrun_q <= 1'b1;
                    if (play_edge)
                        stop_pending <= 1'b1;
                    if (avm_read && !avm_waitrequest)
                        rd_pending <= 1'b1;
                    if (rd_done) begin
                        rd_pending <= 1'b0;
                        staging[ch*DATA_W +: DATA_W] <= avm_readdata;
                        if (last_ch) begin
                            data_out_q <= frame_next;
                            if (stop_pending || play_edge) begin
                                ptr   <= ptr_inc;
                                state <= S_IDLE;
                            end else if (ptr_inc == rec_len_q) begin
`ifdef LOOP_PLAYBACK_EN
                                ptr   <= '0;
                                state <= S_PLAY_WAIT;
`else
                                ptr   <= ptr_inc;
                                state <= S_IDLE;
`endif
                            end else begin
                                ptr   <= ptr_inc;
                                state <= S_PLAY_WAIT;
                            end
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_stream_recorder.sv
// Self-checking bench for audio_stream_recorder: SDRAM model, frame-level reference model, bus monitors.
module tb_audio_stream_recorder;

    localparam int DATA_W   = 16;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 4;
    localparam int FRAME_W  = CHANNELS * DATA_W;

    logic                clk_clk = 1'b0;
    logic                reset_reset_n = 1'b0;
    logic                sync_in = 1'b0;
    logic                record_btn_in = 1'b0;
    logic                play_btn_in = 1'b0;
    logic [FRAME_W-1:0]  data_in = '0;
    logic [FRAME_W-1:0]  data_out;
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic                avm_read;
    logic [DATA_W-1:0]   avm_readdata = '0;
    logic                avm_readdatavalid = 1'b0;
    logic                avm_waitrequest = 1'b0;
    logic [1:0]          mode;
    logic [ADDR_W-1:0]   rec_len;
    logic                overrun;

    audio_stream_recorder #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .sync_in(sync_in),
        .record_btn_in(record_btn_in),
        .play_btn_in(play_btn_in),
        .data_in(data_in),
        .data_out(data_out),
        .avm_address(avm_address),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest),
        .mode(mode),
        .rec_len(rec_len),
        .overrun(overrun)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // SDRAM model: write log, read data returned two cycles after acceptance.
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wlog_a [$];
    logic [DATA_W-1:0] wlog_d [$];
    logic [ADDR_W-1:0] rd_addr = '0;
    int                rd_cnt = 0;
    int                rv_count = 0;
    int                viol = 0;
    bit                outstanding = 0;
    bit                saw_addr14 = 0;

    always @(posedge clk_clk) begin
        if (rd_cnt == 1) begin
            avm_readdatavalid <= 1'b1;
            avm_readdata      <= mem[rd_addr];
            rv_count++;
        end else begin
            avm_readdatavalid <= 1'b0;
        end
        if (rd_cnt != 0)
            rd_cnt <= rd_cnt - 1;
        if (avm_read && !avm_waitrequest) begin
            rd_cnt  <= 2;
            rd_addr <= avm_address;
        end
        if (avm_write && !avm_waitrequest) begin
            mem[avm_address] = avm_writedata;
            wlog_a.push_back(avm_address);
            wlog_d.push_back(avm_writedata);
            if (avm_address == 4'd14)
                saw_addr14 = 1;
        end
        // Protocol monitor: exclusive strobes, strobes only in their mode, one read in flight.
        if (!reset_reset_n) begin
            outstanding = 0;
        end else begin
            if (avm_read && avm_write) viol++;
            if (avm_write && mode != 2'd1) viol++;
            if (avm_read && mode != 2'd2) viol++;
            if (avm_readdatavalid) outstanding = 0;
            if (avm_read && !avm_waitrequest) begin
                if (outstanding) viol++;
                outstanding = 1;
            end
        end
    end

    // Reference model: list of frames the current session should hold.
    logic [FRAME_W-1:0] exp_frames [$];
    int                 sess_base = 0;
    bit                 model_rec = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic press_rec();
        record_btn_in = 1'b1; tick();
        record_btn_in = 1'b0; tick();
    endtask

    task automatic press_play();
        play_btn_in = 1'b1; tick();
        play_btn_in = 1'b0; tick();
    endtask

    task automatic strobe(input logic [FRAME_W-1:0] f);
        data_in = f;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
    endtask

    task automatic start_rec();
        press_rec();
        exp_frames.delete();
        sess_base = wlog_a.size();
        model_rec = 1;
    endtask

    task automatic wait_writes(input string tag, input int target);
        for (int i = 0; i < 50 && wlog_a.size() < target; i++) tick();
        tick(3);
        check(tag, wlog_a.size(), target);
    endtask

    task automatic rec_frame(input logic [FRAME_W-1:0] f);
        int tgt;
        tgt = wlog_a.size() + (model_rec ? CHANNELS : 0);
        strobe(f);
        if (model_rec) begin
            exp_frames.push_back(f);
            if (exp_frames.size() == DEPTH - 1) model_rec = 0;
        end
        wait_writes("rec_write_count", tgt);
    endtask

    task automatic verify_session(input string tag);
        logic [FRAME_W-1:0] fr;
        int idx;
        check({tag, "_nwrites"}, wlog_a.size() - sess_base, exp_frames.size() * CHANNELS);
        check({tag, "_rec_len"}, rec_len, exp_frames.size());
        for (int f = 0; f < exp_frames.size(); f++) begin
            fr = exp_frames[f];
            for (int c = 0; c < CHANNELS; c++) begin
                idx = sess_base + f * CHANNELS + c;
                if (idx < wlog_a.size()) begin
                    check({tag, "_addr"}, wlog_a[idx], f * CHANNELS + c);
                    check({tag, "_data"}, wlog_d[idx], fr[c*DATA_W +: DATA_W]);
                end
            end
        end
    endtask

    task automatic play_one(input string tag, input logic [FRAME_W-1:0] expf);
        int tgt;
        tgt = rv_count + CHANNELS;
        strobe('0);
        for (int i = 0; i < 60 && rv_count < tgt; i++) tick();
        tick(2);
        check({tag, "_valid_count"}, rv_count, tgt);
        check({tag, "_data_out"}, data_out, expf);
    endtask

    task automatic play_session(input string tag);
        press_play();
        check({tag, "_mode_play"}, mode, 2'd2);
        for (int i = 0; i < exp_frames.size(); i++) play_one(tag, exp_frames[i]);
`ifdef LOOP_PLAYBACK_EN
        check({tag, "_mode_loop"}, mode, 2'd2);
        play_one({tag, "_wrap"}, exp_frames[0]);
        press_play();
        check({tag, "_mode_stop"}, mode, 2'd0);
        check({tag, "_hold"}, data_out, exp_frames[0]);
`else
        check({tag, "_mode_end"}, mode, 2'd0);
        check({tag, "_hold"}, data_out, exp_frames[exp_frames.size()-1]);
`endif
    endtask

    initial begin
        logic [FRAME_W-1:0] f;
        int cnt;

        // Reset state
        tick(2);
        #1;
        check("rst_mode", mode, 0);
        check("rst_write", avm_write, 0);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_data_out", data_out, 0);
        check("rst_rec_len", rec_len, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        tick(2);
        check("idle_play_ignored_mode", mode, 0);
        press_play();
        check("play_empty_ignored", mode, 0);

        // Test 1: directed three-frame recording
        start_rec();
        check("t1_mode_rec", mode, 2'd1);
        strobe(32'h0002_0001);
        check("t1_latency_write", avm_write, 1);
        check("t1_latency_addr", avm_address, 0);
        check("t1_latency_data", avm_writedata, 16'h0001);
        exp_frames.push_back(32'h0002_0001);
        wait_writes("t1_f0", sess_base + 2);
        rec_frame(32'h0004_0003);
        rec_frame(32'h0006_0005);
        press_rec();
        model_rec = 0;
        check("t1_mode_idle", mode, 0);
        verify_session("t1");

        // Test 2: playback of test 1
        play_session("t2");

        // Test 3: stalled first write
        start_rec();
        check("t3_rec_len_clear", rec_len, 0);
        f = $urandom;
        avm_waitrequest = 1'b1;
        strobe(f);
        exp_frames.push_back(f);
        for (int k = 0; k < 5; k++) begin
            check("t3_stall_write", avm_write, 1);
            check("t3_stall_addr", avm_address, 0);
            check("t3_stall_data", avm_writedata, f[DATA_W-1:0]);
            if (k < 4) tick();
        end
        check("t3_no_accept_during_stall", wlog_a.size(), sess_base);
        avm_waitrequest = 1'b0;
        wait_writes("t3_writes", sess_base + 2);

        // Test 4: back-to-back strobes -> overrun, second frame dropped
        f = $urandom;
        cnt = wlog_a.size();
        data_in = f;
        sync_in = 1'b1;
        tick();
        data_in = ~f;
        tick();
        sync_in = 1'b0;
        exp_frames.push_back(f);
        wait_writes("t4_one_frame", cnt + 2);
        check("t4_overrun_set", overrun, 1);
        press_rec();
        model_rec = 0;
        check("t4_mode_idle", mode, 0);
        check("t4_overrun_sticky", overrun, 1);
        verify_session("t4");

        // Test 5: fill buffer, auto-stop after DEPTH-1 frames
        start_rec();
        check("t5_overrun_clear", overrun, 0);
        for (int i = 0; i < 8; i++) rec_frame($urandom);
        check("t5_auto_stop_mode", mode, 0);
        check("t5_no_addr14", saw_addr14, 0);
        verify_session("t5");
        play_session("t5");

        // Simultaneous edges in IDLE: record wins
        record_btn_in = 1'b1;
        play_btn_in   = 1'b1;
        tick();
        record_btn_in = 1'b0;
        play_btn_in   = 1'b0;
        tick();
        check("both_edges_record", mode, 2'd1);
        exp_frames.delete();
        sess_base = wlog_a.size();
        model_rec = 1;
        rec_frame($urandom);
        press_rec();
        model_rec = 0;
        verify_session("t5b");

        // Test 6: asynchronous reset during PLAY_RD
        press_play();
        strobe('0);
        for (int i = 0; i < 20 && !avm_read; i++) tick();
        check("t6_read_seen", avm_read, 1);
        #2 reset_reset_n = 1'b0;
        #1;
        check("t6_read_zero", avm_read, 0);
        check("t6_write_zero", avm_write, 0);
        check("t6_addr_zero", avm_address, 0);
        check("t6_mode_zero", mode, 0);
        check("t6_data_out_zero", data_out, 0);
        check("t6_rec_len_zero", rec_len, 0);
        check("t6_overrun_zero", overrun, 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (avm_read) cnt++;
        end
        check("t6_no_read_after", cnt, 0);
        check("t6_mode_idle", mode, 0);

        check("protocol_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
